// File: rtl/decoder_pkg.sv
// Shared definitions for the registered code decoder.
// Holds the decode-mode encodings used by decoder_core and its callers.
package decoder_pkg;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERM  = 1'b1;

endpackage

// File: rtl/decoder_pipe_core.sv
// decoder_core: combinational binary-to-one-hot/thermometer decode.
// Ports: code, mode -> bits (decoded vector), err (code out of range).
module decoder_core
    import decoder_pkg::*;
#(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 20
) (
    input  logic [IN_WIDTH-1:0]  code,
    input  logic                 mode,
    output logic [OUT_WIDTH-1:0] bits,
    output logic                 err
);

    // One extra bit so OUT_WIDTH == 2**IN_WIDTH never flags.
    localparam logic [IN_WIDTH:0] LIMIT = (IN_WIDTH + 1)'(OUT_WIDTH);

    logic in_range;

    assign in_range = {1'b0, code} < LIMIT;

    always_comb begin
        bits = '0;
        err  = !in_range;
        if (in_range) begin
            for (int i = 0; i < OUT_WIDTH; i++) begin
                if (mode == MODE_THERM)
                    bits[i] = (i <= int'(code));
                else
                    bits[i] = (i == int'(code));
            end
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered decoder with a 2-entry output FIFO.
// Ports: in_valid/in_ready/in_code/in_mode, out_valid/out_ready/
// out_bits/out_err, err_clr/err_count (saturating error count).
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 20,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_code,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_bits,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [OUT_WIDTH-1:0] dec_bits;
    logic                 dec_err;
    logic [OUT_WIDTH-1:0] bits0, bits1;
    logic                 err0, err1;
    logic [1:0]           cnt;
    logic                 rdy_q;
    logic                 push, pop;

    decoder_core #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_core (
        .code(in_code),
        .mode(in_mode),
        .bits(dec_bits),
        .err (dec_err)
    );

    // rdy_q keeps in_ready low until the first edge after reset.
    assign in_ready  = rdy_q && (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign out_bits  = bits0;
    assign out_err   = err0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            cnt   <= 2'd0;
            bits0 <= '0;
            bits1 <= '0;
            err0  <= 1'b0;
            err1  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case ({push, pop})
                2'b11: begin
                    // Only reachable at count 1: new entry becomes head.
                    bits0 <= dec_bits;
                    err0  <= dec_err;
                end
                2'b10: begin
                    if (cnt == 2'd0) begin
                        bits0 <= dec_bits;
                        err0  <= dec_err;
                    end else begin
                        bits1 <= dec_bits;
                        err1  <= dec_err;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    bits0 <= bits1;
                    err0  <= err1;
                    cnt   <= cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (err_clr)
            err_count <= '0;
        else if (push && dec_err && (err_count != '1))
            err_count <= err_count + ERR_CNT_W'(1);
    end

endmodule
